fifo_drain: RTL and testbench
=============================

FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the width of the FIFO read data and the output data.
REQ-002 SHALL have parameter ACK_TMO, default 4, the maximum number of cycles to wait for a read acknowledge.
REQ-003 SHALL use one clock and asynchronous active-high reset; the port list follows.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 start  in  1  one-cycle pulse requesting a drain burst.
REQ-007 len  in  4  words to drain; legal range 1..8.
REQ-008 fifo_empty  in  1  FIFO holds no data.
REQ-009 fifo_rd_en  out  1  read request to the FIFO, one cycle per word.
REQ-010 fifo_dout  in  DATA_W  FIFO read data, valid while fifo_rd_ack=1.
REQ-011 fifo_rd_ack  in  1  read completed; fifo_dout valid this cycle.
REQ-012 fifo_rd_err  in  1  FIFO rejected the read (underflow).
REQ-013 out_data  out  DATA_W  word presented downstream.
REQ-014 out_valid  out  1  out_data valid.
REQ-015 out_ready  in  1  downstream accepts the word when out_valid=1.
REQ-016 busy  out  1  burst in progress (state not IDLE).
REQ-017 done  out  1  one-cycle pulse when the burst completes.
REQ-018 err  out  1  sticky error flag; cleared by the next accepted start.
REQ-019 word_cnt  out  4  number of words captured in the current burst.

Function
REQ-020 SHALL implement the states IDLE, REQ, WAIT, DONE and ERROR.
REQ-021 IDLE: on start=1, if len is in 1..8, SHALL load remaining=len, clear word_cnt and err, and go to REQ; if len is 0 or greater than 8, SHALL set err and go to ERROR.
REQ-022 IDLE: when start=0, SHALL stay in IDLE with fifo_rd_en=0.
REQ-023 REQ: when fifo_empty=0 and (out_valid=0 or out_ready=1), SHALL assert fifo_rd_en for exactly one cycle and go to WAIT; otherwise SHALL hold REQ with fifo_rd_en=0.
REQ-024 Only one read SHALL be outstanding at any time.
REQ-025 fifo_rd_en SHALL never be asserted outside REQ.
REQ-026 WAIT: on fifo_rd_ack=1, SHALL perform all of the following in the same edge:
- capture fifo_dout into out_data;
- set out_valid;
- decrement remaining;
- increment word_cnt.
REQ-027 After the capture in REQ-026, SHALL go to DONE if remaining reaches 0, else to REQ.
REQ-028 WAIT: on fifo_rd_err=1, SHALL set err and go to ERROR; fifo_rd_err SHALL take priority over a simultaneous fifo_rd_ack, and no data is captured.
REQ-029 WAIT: if ACK_TMO cycles elapse without ack or error, SHALL set err and go to ERROR; the timeout counter SHALL reset on each entry to WAIT.
REQ-030 DONE: SHALL assert done for one cycle, then go to IDLE.
REQ-031 ERROR: SHALL hold err=1 and go to IDLE the next cycle.
REQ-032 out_valid SHALL fall only on the cycle where out_valid=1 and out_ready=1 and no new capture occurs; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-033 A capture and a downstream accept on the same edge SHALL leave out_valid=1 with the new word.
REQ-034 start SHALL be ignored while busy=1.
REQ-035 The minimum spacing between FIFO reads SHALL be 2 cycles per word (REQ then WAIT); with an immediate ack, an 8-word burst SHALL complete in 16 cycles plus 1 DONE cycle.
REQ-036 remaining SHALL be 4 bits wide and SHALL not wrap below 0.
REQ-037 word_cnt SHALL hold its value after DONE or ERROR until the next accepted start.

Reset
REQ-038 While reset=1, SHALL asynchronously force:
- state to IDLE;
- fifo_rd_en, out_valid, busy, done and err to 0;
- out_data, word_cnt, remaining and the timeout counter to 0.
REQ-039 Reset asserted mid-burst SHALL drop fifo_rd_en immediately; a late fifo_rd_ack after reset release SHALL be ignored in IDLE.

Verification
REQ-040 Normal burst: len=3, FIFO holds A,B,C, ack 1 cycle after rd_en, out_ready=1 -> out_data A,B,C each with out_valid; done pulses once; word_cnt=3; err=0.
REQ-041 Backpressure: len=2, out_ready=0 -> after word 1, fifo_rd_en stays 0 and out_data is held; raising out_ready -> second read issues and burst completes.
REQ-042 Empty stall: len=2, fifo_empty=1 for 5 cycles -> no rd_en and state remains REQ; FIFO fills -> burst completes normally.
REQ-043 Underflow: fifo_rd_err=1 together with fifo_rd_ack in WAIT -> err=1, no capture, busy=0 after 2 cycles, done never pulses.
REQ-044 Illegal length and timeout: len=0 or len=9 -> err=1 and no rd_en; ack withheld 4 cycles -> err=1 and return to IDLE.
REQ-045 Reset mid-burst: reset during WAIT of word 2 of 4 -> all outputs 0 immediately; a late ack is ignored; a fresh start with len=1 works.

Source files
------------

// File: rtl/fifo_drain_if.sv
// Bundle of the handshake signals between the drain engine, the FIFO
// read port and the downstream consumer. The master side is the drain
// engine; the slave side is whatever sits around it.
interface fifo_drain_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [3:0]        len;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd_ack;
    logic              fifo_rd_err;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [3:0]        word_cnt;

    modport master (
        input  start, len, fifo_empty, fifo_dout, fifo_rd_ack, fifo_rd_err, out_ready,
        output fifo_rd_en, out_data, out_valid, busy, done, err, word_cnt
    );

    modport slave (
        output start, len, fifo_empty, fifo_dout, fifo_rd_ack, fifo_rd_err, out_ready,
        input  fifo_rd_en, out_data, out_valid, busy, done, err, word_cnt
    );
endinterface

// File: rtl/fifo_drain.sv
// Burst drain engine: on a start pulse, reads len words (1..8) from a FIFO
// one at a time, waiting for each read acknowledge, and hands every word
// downstream through a valid/ready output register. Read errors, ack
// timeouts and illegal lengths end the burst with a sticky error flag.
module fifo_drain #(
    parameter int DATA_W  = 32,
    parameter int ACK_TMO = 4
) (
    input  logic         clk,
    input  logic         reset,
    fifo_drain_if.master bus
);

    localparam int TMO_W = $clog2(ACK_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_outData;
    logic              r_outValid;
    logic              r_done;
    logic              r_err;
    logic [3:0]        r_wordCnt;
    logic [3:0]        r_remaining;
    logic [TMO_W-1:0]  r_tmo;

    logic w_canRead;
    logic w_lenOk;

    // A read may issue only when data exists and the output register is free
    // or being emptied this cycle. The read strobe is decoded from the state
    // so it is only ever high while in REQ, lasts exactly the one cycle that
    // REQ moves on to WAIT, and drops the instant reset forces IDLE.
    always_comb begin
        w_canRead = !bus.fifo_empty && (!r_outValid || bus.out_ready);
        w_lenOk   = (bus.len != 4'd0) && (bus.len <= 4'd8);
    end

    assign bus.fifo_rd_en = (r_state == S_REQ) && w_canRead;
    assign bus.out_data   = r_outData;
    assign bus.out_valid  = r_outValid;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.word_cnt   = r_wordCnt;

    // Burst state machine together with the output register, counters and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_outData   <= '0;
            r_outValid  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_wordCnt   <= 4'd0;
            r_remaining <= 4'd0;
            r_tmo       <= '0;
        end else begin
            r_done <= 1'b0;

            if (r_outValid && bus.out_ready) begin
                r_outValid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_lenOk) begin
                            r_remaining <= bus.len;
                            r_wordCnt   <= 4'd0;
                            r_err       <= 1'b0;
                            r_state     <= S_REQ;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_ERROR;
                        end
                    end
                end

                S_REQ: begin
                    if (w_canRead) begin
                        r_tmo   <= '0;
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus.fifo_rd_err) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERROR;
                    end else if (bus.fifo_rd_ack) begin
                        r_outData  <= bus.fifo_dout;
                        r_outValid <= 1'b1;
                        r_wordCnt  <= r_wordCnt + 4'd1;
                        if (r_remaining != 4'd0) begin
                            r_remaining <= r_remaining - 4'd1;
                        end
                        if (r_remaining <= 4'd1) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERROR;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                S_ERROR: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: a cycle-by-cycle vector table for the
// normal, backpressure and empty-stall bursts, then hand-written sequences
// for underflow, timeout, illegal lengths and reset in mid-burst.
module tb_fifo_drain;

    localparam logic [31:0] A  = 32'hA0A0_0001;
    localparam logic [31:0] B  = 32'hB0B0_0002;
    localparam logic [31:0] C  = 32'hC0C0_0003;
    localparam logic [31:0] D  = 32'hD0D0_0004;
    localparam logic [31:0] E  = 32'hE0E0_0005;
    localparam logic [31:0] F  = 32'hF0F0_0006;
    localparam logic [31:0] G  = 32'h1234_0007;
    localparam logic [31:0] H  = 32'hDEAD_0008;
    localparam logic [31:0] I  = 32'h5555_0009;
    localparam logic [31:0] J  = 32'h6666_000A;
    localparam logic [31:0] K  = 32'h7777_000B;
    localparam logic [31:0] K2 = 32'h8888_000C;

    typedef struct {
        logic        start;
        logic [3:0]  len;
        logic        empty;
        logic [31:0] dout;
        logic        ack;
        logic        rdErr;
        logic        ready;
        logic        expRdEn;
        logic        expValid;
        logic [31:0] expData;
        logic        expBusy;
        logic        expDone;
        logic        expErr;
        logic [3:0]  expWc;
    } vec_t;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    vec_t vecs[$];

    fifo_drain_if #(.DATA_W(32)) bus ();

    fifo_drain #(.DATA_W(32), .ACK_TMO(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(int st, int ln, int emp, logic [31:0] dout, int ack, int rerr,
                                int rdy, int eRd, int eVal, logic [31:0] eData, int eBusy,
                                int eDone, int eErr, int eWc);
        vec_t v;
        v.start    = st[0];
        v.len      = ln[3:0];
        v.empty    = emp[0];
        v.dout     = dout;
        v.ack      = ack[0];
        v.rdErr    = rerr[0];
        v.ready    = rdy[0];
        v.expRdEn  = eRd[0];
        v.expValid = eVal[0];
        v.expData  = eData;
        v.expBusy  = eBusy[0];
        v.expDone  = eDone[0];
        v.expErr   = eErr[0];
        v.expWc    = eWc[3:0];
        return v;
    endfunction

    task automatic checkField(string tag, string field, logic [31:0] got, logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s %s: got %0h, want %0h", tag, field, got, want);
        end
    endtask

    task automatic checkOutput(string tag, int rd, int val, logic [31:0] data, int busy,
                               int done, int err, int wc);
        checkField(tag, "fifo_rd_en", 32'(bus.fifo_rd_en), 32'(rd));
        checkField(tag, "out_valid",  32'(bus.out_valid),  32'(val));
        checkField(tag, "out_data",   bus.out_data,        data);
        checkField(tag, "busy",       32'(bus.busy),       32'(busy));
        checkField(tag, "done",       32'(bus.done),       32'(done));
        checkField(tag, "err",        32'(bus.err),        32'(err));
        checkField(tag, "word_cnt",   32'(bus.word_cnt),   32'(wc));
    endtask

    task automatic applyStimulus(int st, int ln, int emp, logic [31:0] dout, int ack, int rerr,
                                 int rdy);
        @(negedge clk);
        bus.start       = st[0];
        bus.len         = ln[3:0];
        bus.fifo_empty  = emp[0];
        bus.fifo_dout   = dout;
        bus.fifo_rd_ack = ack[0];
        bus.fifo_rd_err = rerr[0];
        bus.out_ready   = rdy[0];
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        bus.start       = 1'b0;
        bus.len         = 4'd0;
        bus.fifo_empty  = 1'b1;
        bus.fifo_dout   = '0;
        bus.fifo_rd_ack = 1'b0;
        bus.fifo_rd_err = 1'b0;
        bus.out_ready   = 1'b0;

        // normal burst, len=3, immediate acks, downstream always ready
        vecs.push_back(mk(1, 3, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, A, 1, 0, 1,  0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, A, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, B, 1, 0, 1,  0, 0, A, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, B, 1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, C, 1, 0, 1,  0, 0, B, 1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 1, C, 1, 1, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, C, 0, 0, 0, 3));
        // backpressure, len=2: second read waits for out_ready, data held
        vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0,  0, 0, C, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, C, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, D, 1, 0, 0,  0, 0, C, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, D, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, E, 0, 0, 0,  0, 1, D, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, D, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, E, 1, 0, 1,  0, 0, D, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 1, E, 1, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, E, 0, 0, 0, 2));
        // empty stall, len=2: five cycles of empty FIFO in REQ
        vecs.push_back(mk(1, 2, 1, 0, 0, 0, 1,  0, 0, E, 0, 0, 0, 2));
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1,  0, 0, E, 1, 0, 0, 0));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 0, E, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, F, 1, 0, 1,  0, 0, E, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, F, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, G, 1, 0, 1,  0, 0, F, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 1, G, 1, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, G, 0, 0, 0, 2));

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].start, vecs[i].len, vecs[i].empty, vecs[i].dout,
                          vecs[i].ack, vecs[i].rdErr, vecs[i].ready);
            checkOutput($sformatf("row%0d", i), vecs[i].expRdEn, vecs[i].expValid,
                        vecs[i].expData, vecs[i].expBusy, vecs[i].expDone,
                        vecs[i].expErr, vecs[i].expWc);
        end

        // underflow: error beats a simultaneous ack, nothing captured, no done
        applyStimulus(1, 2, 0, 0, 0, 0, 1); checkOutput("uf start",  0, 0, G, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("uf req",    1, 0, G, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, H, 1, 1, 1); checkOutput("uf wait",   0, 0, G, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("uf error",  0, 0, G, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("uf idle",   0, 0, G, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("uf sticky", 0, 0, G, 0, 0, 1, 0);

        // ack timeout: four WAIT cycles with no response
        applyStimulus(1, 1, 0, 0, 0, 0, 1); checkOutput("tmo start", 0, 0, G, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("tmo req",   1, 0, G, 1, 0, 0, 0);
        for (int w = 0; w < 4; w++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
            checkOutput($sformatf("tmo wait%0d", w), 0, 0, G, 1, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("tmo error", 0, 0, G, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("tmo idle",  0, 0, G, 0, 0, 1, 0);

        // single-word burst clears the sticky error
        applyStimulus(1, 1, 0, 0, 0, 0, 1); checkOutput("one start", 0, 0, G, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("one req",   1, 0, G, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, I, 1, 0, 1); checkOutput("one wait",  0, 0, G, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("one done",  0, 1, I, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("one idle",  0, 0, I, 0, 0, 0, 1);

        // illegal lengths 0 and 9: error, no read, word_cnt held
        applyStimulus(1, 0, 0, 0, 0, 0, 1); checkOutput("len0 start", 0, 0, I, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("len0 error", 0, 0, I, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("len0 idle",  0, 0, I, 0, 0, 1, 1);
        applyStimulus(1, 9, 0, 0, 0, 0, 1); checkOutput("len9 start", 0, 0, I, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("len9 error", 0, 0, I, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("len9 idle",  0, 0, I, 0, 0, 1, 1);

        // reset during WAIT of word 2 of 4, with a start pulse ignored while busy
        applyStimulus(1, 4, 0, 0, 0, 0, 1); checkOutput("rst start", 0, 0, I, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("rst req1",  1, 0, I, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, J, 1, 0, 1); checkOutput("rst wait1", 0, 0, I, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1); checkOutput("rst req2",  1, 1, J, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("rst wait2", 0, 0, J, 1, 0, 0, 1);
        reset = 1'b1;
        #1;
        checkOutput("rst asserted", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset           = 1'b0;
        bus.fifo_dout   = K;
        bus.fifo_rd_ack = 1'b1;
        #1;
        checkOutput("rst late ack", 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("rst ignored", 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 1); checkOutput("fresh start", 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("fresh req",   1, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, K2, 1, 0, 1); checkOutput("fresh wait", 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("fresh done",  0, 1, K2, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); checkOutput("fresh idle",  0, 0, K2, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
